// File: rtl/indexed_shift_buffer.sv
// Registered index-ordered entry buffer with insert (right shift), delete (left shift) and clear.
// A full-buffer insert evicts the tail entry on a side port.
module indexed_shift_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [1:0]               op_code,
  input  logic [IDX_W-1:0]         op_idx,
  input  logic [WIDTH-1:0]         op_data,
  output logic [WIDTH*DEPTH-1:0]   arr,
  output logic [IDX_W:0]           count,
  output logic                     full,
  output logic                     empty,
  output logic                     evict_valid,
  output logic [WIDTH-1:0]         evict_data,
  output logic                     err
);

  typedef enum logic [1:0] {
    OpNop    = 2'b00,
    OpInsert = 2'b01,
    OpDelete = 2'b10,
    OpClear  = 2'b11
  } op_e;

  localparam logic [IDX_W:0] CntOne  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CntFull = (IDX_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IDX_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             evict_valid_q, evict_valid_d;
  logic [WIDTH-1:0] evict_data_q, evict_data_d;
  logic             err_q, err_d;
  logic             accept;
  logic [IDX_W:0]   idx_ext;

  assign op_ready = ~rst;
  assign accept   = op_valid & op_ready;
  assign idx_ext  = {1'b0, op_idx};

  always_comb begin
    mem_d         = mem_q;
    count_d       = count_q;
    evict_valid_d = 1'b0;
    evict_data_d  = evict_data_q;
    err_d         = 1'b0;
    if (accept) begin
      unique case (op_e'(op_code))
        OpInsert: begin
          if (idx_ext > count_q) begin
            err_d = 1'b1;
          end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
              if (IDX_W'(i) > op_idx) mem_d[i] = mem_q[i-1];
            end
            mem_d[op_idx] = op_data;
            if (full_q) begin
              // Tail falls off the end; count stays saturated.
              evict_valid_d = 1'b1;
              evict_data_d  = mem_q[DEPTH-1];
            end else begin
              count_d = count_q + CntOne;
            end
          end
        end
        OpDelete: begin
          if (idx_ext >= count_q) begin
            err_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
              if (IDX_W'(i) >= op_idx) mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
            count_d        = count_q - CntOne;
          end
        end
        OpClear: begin
          for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
          count_d = '0;
        end
        OpNop: ;
        default: ;
      endcase
    end
    full_d  = (count_d == CntFull);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
      err_q         <= err_d;
    end
  end

  // Entry 0 lands in the most significant slice.
  for (genvar g = 0; g < DEPTH; g++) begin : g_arr
    assign arr[WIDTH*(DEPTH-1-g) +: WIDTH] = mem_q[g];
  end

  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_indexed_shift_buffer.sv
// Scoreboard bench for indexed_shift_buffer: a queue-based reference model feeds expected
// responses to a monitor, plus directed hand-computed entry checks.
module tb_indexed_shift_buffer;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   op_valid = 1'b0;
  logic                   op_ready;
  logic [1:0]             op_code = 2'b00;
  logic [IDX_W-1:0]       op_idx = '0;
  logic [WIDTH-1:0]       op_data = '0;
  logic [WIDTH*DEPTH-1:0] arr;
  logic [IDX_W:0]         count;
  logic                   full, empty, evict_valid, err;
  logic [WIDTH-1:0]       evict_data;

  indexed_shift_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_idx(op_idx), .op_data(op_data), .arr(arr), .count(count), .full(full),
    .empty(empty), .evict_valid(evict_valid), .evict_data(evict_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH*DEPTH-1:0] arr;
    logic [IDX_W:0]         count;
    logic                   ev;
    logic [WIDTH-1:0]       evd;
    logic                   err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] last_ev = '0;
  int               vectors = 0;
  int               miscompares = 0;
  logic             acc_q = 1'b0;

  function automatic void chk(string name, logic [WIDTH*DEPTH-1:0] act,
                              logic [WIDTH*DEPTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [WIDTH-1:0] ent(int i);
    return arr[WIDTH*(DEPTH-1-i) +: WIDTH];
  endfunction

  // Reference model built on a SV queue; evicts by popping the overflowed tail.
  function automatic void push_exp(logic [1:0] c, int idx, logic [WIDTH-1:0] d);
    exp_t e;
    e.ev  = 1'b0;
    e.err = 1'b0;
    case (c)
      2'b01: begin
        if (idx > mq.size()) e.err = 1'b1;
        else begin
          mq.insert(idx, d);
          if (mq.size() > DEPTH) begin
            last_ev = mq.pop_back();
            e.ev    = 1'b1;
          end
        end
      end
      2'b10: begin
        if (idx >= mq.size()) e.err = 1'b1;
        else mq.delete(idx);
      end
      2'b11: mq.delete();
      default: ;
    endcase
    e.evd   = last_ev;
    e.count = (IDX_W+1)'(mq.size());
    e.arr   = '0;
    for (int i = 0; i < mq.size(); i++) e.arr[WIDTH*(DEPTH-1-i) +: WIDTH] = mq[i];
    sb.push_back(e);
  endfunction

  task automatic do_op(input logic [1:0] c, input int idx, input logic [WIDTH-1:0] d);
    op_valid = 1'b1;
    op_code  = c;
    op_idx   = idx[IDX_W-1:0];
    op_data  = d;
    push_exp(c, idx, d);
    @(negedge clk);
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op_code  = 2'b00;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= op_valid && op_ready;
  end

  always @(negedge clk) begin
    exp_t e;
    if (acc_q) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got response with empty queue (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("arr", arr, e.arr);
        chk("count", count, e.count);
        chk("full", full, e.count == (IDX_W+1)'(DEPTH));
        chk("empty", empty, e.count == '0);
        chk("evict_valid", evict_valid, e.ev);
        chk("evict_data", evict_data, e.evd);
        chk("err", err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_arr", arr, '0);
    chk("rst_count", count, '0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_evict_valid", evict_valid, 1'b0);
    chk("rst_evict_data", evict_data, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_op_ready", op_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_op(2'b01, 0, 32'hA);
    chk("empty_after_first", empty, 1'b0);
    do_op(2'b01, 0, 32'hB);
    do_op(2'b01, 0, 32'hC);
    chk("e0_C", ent(0), 32'hC);
    chk("e1_B", ent(1), 32'hB);
    chk("e2_A", ent(2), 32'hA);
    chk("count3", count, 5'd3);

    do_op(2'b01, 3, 32'hD);
    chk("e3_D", ent(3), 32'hD);
    do_op(2'b01, 5, 32'hEE);
    chk("ins_gap_err", err, 1'b1);
    chk("ins_gap_count", count, 5'd4);
    do_op(2'b00, 0, 32'h0);
    chk("err_one_cycle", err, 1'b0);

    do_op(2'b11, 7, 32'h55);
    for (int i = 0; i < DEPTH; i++) do_op(2'b01, i, WIDTH'(i + 1));
    chk("full_after_fill", full, 1'b1);
    do_op(2'b01, 4, 32'h99);
    chk("evict_pulse", evict_valid, 1'b1);
    chk("evict_16", evict_data, 32'd16);
    chk("e4_99", ent(4), 32'h99);
    chk("e5_5", ent(5), 32'd5);
    chk("count_full", count, 5'd16);

    do_op(2'b10, 0, 32'h0);
    chk("evict_drops", evict_valid, 1'b0);
    chk("del_e0", ent(0), 32'd2);
    chk("del_e15", ent(15), 32'd0);
    chk("del_count", count, 5'd15);
    chk("del_full", full, 1'b0);
    do_op(2'b10, 15, 32'h0);
    chk("del_oob_err", err, 1'b1);

    do_op(2'b11, 0, 32'h0);
    do_op(2'b10, 0, 32'h0);
    chk("del_empty_err", err, 1'b1);
    do_op(2'b01, 0, 32'h7);
    do_op(2'b11, 3, 32'h1234);
    chk("clr_count", count, '0);
    chk("clr_arr", arr, '0);
    chk("clr_empty", empty, 1'b1);

    for (int i = 0; i < 5; i++) do_op(2'b01, 0, WIDTH'(32'h100 + i));
    // Accepted INSERT in flight when reset lands mid-cycle.
    op_valid = 1'b1;
    op_code  = 2'b01;
    op_idx   = 4'd2;
    op_data  = 32'hDEAD;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_arr", arr, '0);
    chk("mid_rst_count", count, '0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_evict", evict_valid, 1'b0);
    chk("mid_rst_evict_data", evict_data, '0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_ready", op_ready, 1'b0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    mq.delete();
    last_ev = '0;
    @(negedge clk);
    chk("post_rst_count", count, '0);
    chk("post_rst_err", err, 1'b0);
    chk("post_rst_evict", evict_valid, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/indexed_shift_buffer.md
# indexed_shift_buffer

Registered, parametrised successor to the combinational indexed right-shift array. It holds up to DEPTH entries of WIDTH bits in index order, with occupancy tracking and per-cycle operations. Operations are insert-at-index (right shift), delete-at-index (left shift) and clear. A full-buffer insert evicts the tail entry on a side port. It sits in the SpMM datapath as the sorted column-index / partial-product list that the merge logic builds and drains.

## Interface
- WIDTH, 32, bits per entry
- DEPTH, 16, number of entries; must be a power of two, ≥ 2
- IDX_W, $clog2(DEPTH), index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  operation request
- op_ready  out  1  buffer can accept an operation this cycle
- op_code  in  2  00 NOP, 01 INSERT, 10 DELETE, 11 CLEAR
- op_idx  in  IDX_W  target index
- op_data  in  WIDTH  value for INSERT
- arr  out  WIDTH*DEPTH  registered contents; entry 0 in the most significant WIDTH bits, entry DEPTH-1 in the least significant bits
- count  out  IDX_W+1  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- evict_valid  out  1  one-cycle pulse: a tail entry was pushed out
- evict_data  out  WIDTH  evicted entry, valid with evict_valid
- err  out  1  one-cycle pulse: the last accepted operation was illegal and ignored

## Operation
- Accept = op_valid && op_ready. op_ready is 1 at all times except when rst is asserted.
- Entries at index ≥ count are always zero.
- INSERT, op_idx < count, not full:
  - entries op_idx..count-1 move to op_idx+1..count.
  - entry op_idx = op_data.
  - count += 1.
- INSERT, op_idx == count, not full: append at op_idx; count += 1.
- INSERT, full:
  - entry DEPTH-1 goes to evict_data and evict_valid pulses.
  - shift and write as above.
  - count stays DEPTH.
- INSERT, op_idx > count: illegal. err pulses; arr and count unchanged.
- DELETE, op_idx < count:
  - entries op_idx+1..DEPTH-1 move to op_idx..DEPTH-2.
  - entry DEPTH-1 = 0.
  - count -= 1.
- DELETE, op_idx ≥ count (includes empty): illegal. err pulses; no change.
- CLEAR: all entries 0, count 0. op_idx and op_data are ignored.
- NOP, or op_valid low: no change, no pulses.
- err and evict_valid are never both 1 in the same cycle.

## Timing
- Reset (async assert, released synchronously by the environment):
  - arr = 0, count = 0, empty = 1, full = 0.
  - evict_valid = 0, evict_data = 0, err = 0, op_ready = 0.
- Single-cycle latency. An op accepted in cycle N updates arr, count, full and empty at the rising edge ending cycle N; the new values are visible in cycle N+1.
- evict_valid, evict_data and err are registered and valid in cycle N+1 for exactly one cycle. evict_data holds its last value when evict_valid is 0.
- Back-to-back operations are legal every cycle, and each one sees the result of its predecessor.
- full and empty are registered, derived from the next count, never combinational from op_*.
- rst asserted mid-stream:
  - the op in flight is discarded.
  - all outputs take their reset values immediately (asynchronously).
  - no err or evict pulse is produced.
- No combinational path from op_* inputs to any output.

## Test plan
- Reset, then INSERT idx 0 with data 0xA, 0xB, 0xC in three consecutive cycles:
  - arr entries 0..2 = 0xC, 0xB, 0xA.
  - count = 3; empty 1→0 after the first edge.
- From [0xC,0xB,0xA]:
  - INSERT idx 3 data 0xD gives [0xC,0xB,0xA,0xD], count 4.
  - Then INSERT idx 5 gives err pulse for 1 cycle, arr and count unchanged.
- Fill to DEPTH=16 with values 1..16 (entry i = i+1):
  - full = 1.
  - INSERT idx 4 data 0x99 gives evict_valid pulse with evict_data = 16, entry 4 = 0x99, entry 5 = 5, count = 16.
- From the full buffer:
  - DELETE idx 0 gives entry 0 = 2, entry 15 = 0, count 15, full 0.
  - DELETE idx 15 then gives err pulse.
- When empty, DELETE idx 0 gives err. INSERT idx 0 data 0x7 followed by CLEAR gives count 0, arr all zero, empty 1.
- Insert 5 entries, then assert rst asynchronously mid-cycle alongside an accepted INSERT: all outputs at reset values before the next edge, no err or evict pulse, count 0 after release.
